// File: rtl/bram_dma_loader.sv
// ============================================================================
//  Module   : bram_dma_loader
//  Purpose  : Stream-to-BRAM DMA responder; writes a valid/ready/last word
//             stream into BRAM from a latched base address, then pulses done.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bram_dma_loader #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dma_go_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  xfer_len_i,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_valid_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    output logic              bram_we_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [DATA_W-1:0] bram_wdata_o,
    output logic              dma_done_o,
    output logic              len_err_o,
    output logic              busy_o,
    output logic [LEN_W-1:0]  words_done_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               bram_we_q, bram_we_d;
    logic [ADDR_W-1:0]  bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0]  bram_wdata_q, bram_wdata_d;
    logic               dma_done_q, dma_done_d;
    logic               len_err_q, len_err_d;
    logic [LEN_W-1:0]   words_done_q, words_done_d;

    logic               w_in_xfer;
    logic               w_beat;
    logic               w_final;

    // Ready depends on the state register only, never on s_valid.
    assign w_in_xfer = (state_q == ST_XFER);
    assign w_beat    = s_valid_i & w_in_xfer;
    assign w_final   = (cnt_q == (len_q - LEN_W'(1)));

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        bram_we_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
        bram_wdata_d = bram_wdata_q;
        dma_done_d   = 1'b0;
        len_err_d    = 1'b0;
        words_done_d = words_done_q;

        case (state_q)
            ST_IDLE: begin
                if (dma_go_i) begin
                    cnt_d        = '0;
                    words_done_d = '0;
                    if (xfer_len_i != '0) begin
                        state_d = ST_XFER;
                        base_d  = base_addr_i;
                        len_d   = xfer_len_i;
                    end else begin
                        dma_done_d = 1'b1;
                    end
                end
            end
            ST_XFER: begin
                if (w_beat) begin
                    bram_we_d    = 1'b1;
                    bram_addr_d  = base_q + ADDR_W'(cnt_q);
                    bram_wdata_d = s_data_i;
                    cnt_d        = cnt_q + LEN_W'(1);
                    words_done_d = cnt_q + LEN_W'(1);
                    if (w_final || s_last_i) begin
                        state_d    = ST_IDLE;
                        dma_done_d = 1'b1;
                        // Error when the marker and the count disagree on the end.
                        len_err_d  = s_last_i ^ w_final;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_wdata_q <= '0;
            dma_done_q   <= 1'b0;
            len_err_q    <= 1'b0;
            words_done_q <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
            dma_done_q   <= dma_done_d;
            len_err_q    <= len_err_d;
            words_done_q <= words_done_d;
        end
    end

    assign s_ready_o    = w_in_xfer;
    assign busy_o       = w_in_xfer;
    assign bram_we_o    = bram_we_q;
    assign bram_addr_o  = bram_addr_q;
    assign bram_wdata_o = bram_wdata_q;
    assign dma_done_o   = dma_done_q;
    assign len_err_o    = len_err_q;
    assign words_done_o = words_done_q;

endmodule

`default_nettype wire
